// File: rtl/mem_lsu_stage_pkg.sv
// Shared definitions for the MEM/LSU stage and its lane-alignment helper.
// Holds the mem_op encodings, exception codes, FSM state encoding, common
// constants and small op-decoding helpers.
package mem_lsu_stage_pkg;

  // mem_op encodings; any value above MOP_SW behaves as MOP_NONE
  localparam logic [3:0] MOP_NONE = 4'd0;
  localparam logic [3:0] MOP_LB   = 4'd1;
  localparam logic [3:0] MOP_LBU  = 4'd2;
  localparam logic [3:0] MOP_LH   = 4'd3;
  localparam logic [3:0] MOP_LHU  = 4'd4;
  localparam logic [3:0] MOP_LW   = 4'd5;
  localparam logic [3:0] MOP_SB   = 4'd6;
  localparam logic [3:0] MOP_SH   = 4'd7;
  localparam logic [3:0] MOP_SW   = 4'd8;

  typedef enum logic [1:0] {
    EXC_NONE           = 2'd0,
    EXC_LOAD_MISALIGN  = 2'd1,
    EXC_STORE_MISALIGN = 2'd2,
    EXC_BUS_TIMEOUT    = 2'd3
  } excp_code_e;

  // FSM state encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [4:0]  NOP_REG_ADDR = 5'd0;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= MOP_LB) && (op <= MOP_LW);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op >= MOP_SB) && (op <= MOP_SW);
  endfunction

  // Access width in bytes (0 for a non-memory op)
  function automatic logic [2:0] op_bytes(input logic [3:0] op);
    case (op)
      MOP_LB, MOP_LBU, MOP_SB: return 3'd1;
      MOP_LH, MOP_LHU, MOP_SH: return 3'd2;
      MOP_LW, MOP_SW:          return 3'd4;
      default:                 return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic for a big-endian 32-bit data bus.
// Store side: byte enables, lane-replicated write data, misalignment flag.
// Load side: selects the addressed lane from the read word and extends it.
// Ports:
//   st_op/st_addr/sdata   -> be, wdata, misaligned   (request side)
//   ld_op/ld_addr/rdata   -> ld_data                 (response side)
module lsu_lane_align
  import mem_lsu_stage_pkg::*;
(
  input  logic [3:0]  st_op,
  input  logic [1:0]  st_addr,
  input  logic [31:0] sdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned,
  input  logic [3:0]  ld_op,
  input  logic [1:0]  ld_addr,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  always_comb begin
    be         = 4'b0000;
    wdata      = ZERO_WORD;
    misaligned = 1'b0;
    case (op_bytes(st_op))
      3'd1: begin
        be    = 4'b1000 >> st_addr;   // bit3 is byte address 00
        wdata = {4{sdata[7:0]}};
      end
      3'd2: begin
        be         = st_addr[1] ? 4'b0011 : 4'b1100;
        wdata      = {2{sdata[15:0]}};
        misaligned = st_addr[0];
      end
      3'd4: begin
        be         = 4'b1111;
        wdata      = sdata;
        misaligned = |st_addr;
      end
      default: ;
    endcase
  end

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (ld_addr)
      2'd0:    byte_sel = rdata[31:24];
      2'd1:    byte_sel = rdata[23:16];
      2'd2:    byte_sel = rdata[15:8];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = ld_addr[1] ? rdata[15:0] : rdata[31:16];
    case (ld_op)
      MOP_LB:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      MOP_LBU: ld_data = {24'h0, byte_sel};
      MOP_LH:  ld_data = {{16{half_sel[15]}}, half_sel};
      MOP_LHU: ld_data = {16'h0, half_sel};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu_stage.sv
// Pipelined MEM stage: registers EX results into the MEM/WB slot and runs
// load/store accesses to data memory over a req/ack handshake, with lane
// steering, load extension, misalignment exceptions and a bus timeout.
// Ports:
//   clk, rst (async, active low)
//   valid_i/ready_o/flush_i, wd_i/wreg_i/wdata_i, mem_op_i/mem_addr_i/mem_sdata_i : EX/MEM input
//   dm_req_o/dm_we_o/dm_be_o/dm_addr_o/dm_wdata_o, dm_ack_i/dm_rdata_i             : data memory
//   wb_valid_o/wd_o/wreg_o/wdata_o                                                  : MEM/WB output
//   stall_req_o, excp_o/excp_code_o/excp_addr_o                                     : control
module mem_lsu_stage
  import mem_lsu_stage_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int ADDR_W     = 32,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  flush_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [31:0]           mem_sdata_i,
  output logic                  dm_req_o,
  output logic                  dm_we_o,
  output logic [3:0]            dm_be_o,
  output logic [ADDR_W-1:0]     dm_addr_o,
  output logic [31:0]           dm_wdata_o,
  input  logic                  dm_ack_i,
  input  logic [31:0]           dm_rdata_i,
  output logic                  wb_valid_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic                  stall_req_o,
  output logic                  excp_o,
  output logic [1:0]            excp_code_o,
  output logic [ADDR_W-1:0]     excp_addr_o
);

  logic [0:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [3:0]            op_lat;
  logic [ADDR_W-1:0]     addr_lat;
  logic [REG_ADDR_W-1:0] wd_lat;
  logic                  wreg_lat;
  logic                  flush_lat;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic        st_misaligned;
  logic [31:0] ld_data;

  // Request side is fed from the incoming instruction; response side from
  // the op/address latched when the request was issued.
  lsu_lane_align u_lane (
    .st_op      (mem_op_i),
    .st_addr    (mem_addr_i[1:0]),
    .sdata      (mem_sdata_i),
    .be         (st_be),
    .wdata      (st_wdata),
    .misaligned (st_misaligned),
    .ld_op      (op_lat),
    .ld_addr    (addr_lat[1:0]),
    .rdata      (dm_rdata_i),
    .ld_data    (ld_data)
  );

  logic accept;
  logic is_mem;
  logic timeout_hit;

  assign accept      = (state == ST_IDLE) && valid_i && !flush_i;
  assign is_mem      = op_is_load(mem_op_i) || op_is_store(mem_op_i);
  // Counter starts at 0 in the first WAIT cycle, so the request is held
  // for exactly TIMEOUT cycles before it is abandoned.
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  // Gated by rst so every output reads 0 while reset is asserted.
  assign ready_o     = rst && (state == ST_IDLE);
  assign stall_req_o = (state == ST_WAIT) && !dm_ack_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      op_lat      <= MOP_NONE;
      addr_lat    <= '0;
      wd_lat      <= '0;
      wreg_lat    <= 1'b0;
      flush_lat   <= 1'b0;
      dm_req_o    <= 1'b0;
      dm_we_o     <= 1'b0;
      dm_be_o     <= 4'b0000;
      dm_addr_o   <= '0;
      dm_wdata_o  <= ZERO_WORD;
      wb_valid_o  <= 1'b0;
      wd_o        <= '0;
      wreg_o      <= 1'b0;
      wdata_o     <= ZERO_WORD;
      excp_o      <= 1'b0;
      excp_code_o <= EXC_NONE;
      excp_addr_o <= '0;
    end else begin
      // WB slot and exception are single-cycle unless refreshed below
      wb_valid_o  <= 1'b0;
      wd_o        <= '0;
      wreg_o      <= 1'b0;
      wdata_o     <= ZERO_WORD;
      excp_o      <= 1'b0;
      excp_code_o <= EXC_NONE;

      if (state == ST_IDLE) begin
        if (accept) begin
          if (!is_mem) begin
            wb_valid_o <= 1'b1;
            wd_o       <= wd_i;
            wreg_o     <= wreg_i;
            wdata_o    <= wdata_i;
          end else if (st_misaligned) begin
            wb_valid_o  <= 1'b1;
            wd_o        <= wd_i;
            excp_o      <= 1'b1;
            excp_code_o <= op_is_load(mem_op_i) ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN;
            excp_addr_o <= mem_addr_i;
          end else begin
            dm_req_o   <= 1'b1;
            dm_we_o    <= op_is_store(mem_op_i);
            dm_be_o    <= st_be;
            dm_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
            dm_wdata_o <= st_wdata;
            op_lat     <= mem_op_i;
            addr_lat   <= mem_addr_i;
            wd_lat     <= wd_i;
            wreg_lat   <= wreg_i;
            flush_lat  <= 1'b0;
            cnt        <= '0;
            state      <= ST_WAIT;
          end
        end
      end else begin
        cnt <= cnt + 1'b1;
        if (flush_i) flush_lat <= 1'b1;
        // Ack is checked first so it wins over a coincident timeout.
        if (dm_ack_i) begin
          dm_req_o   <= 1'b0;
          state      <= ST_IDLE;
          cnt        <= '0;
          wb_valid_o <= 1'b1;
          wd_o       <= wd_lat;
          if (op_is_load(op_lat)) begin
            // A flush never aborts the bus access, it only kills the write.
            wreg_o  <= wreg_lat && !flush_lat && !flush_i;
            wdata_o <= ld_data;
          end
        end else if (timeout_hit) begin
          dm_req_o    <= 1'b0;
          state       <= ST_IDLE;
          cnt         <= '0;
          wb_valid_o  <= 1'b1;
          wd_o        <= wd_lat;
          excp_o      <= 1'b1;
          excp_code_o <= EXC_BUS_TIMEOUT;
          excp_addr_o <= addr_lat;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Self-checking bench for mem_lsu_stage: directed cases plus randomized
// transactions compared against an arithmetic model of the lane rules.
module tb_mem_lsu_stage;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        flush_i = 1'b0;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic [3:0]  mem_op_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_sdata_i = '0;
  logic        dm_req_o;
  logic        dm_we_o;
  logic [3:0]  dm_be_o;
  logic [31:0] dm_addr_o;
  logic [31:0] dm_wdata_o;
  logic        dm_ack_i = 1'b0;
  logic [31:0] dm_rdata_i = '0;
  logic        wb_valid_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o;
  logic        excp_o;
  logic [1:0]  excp_code_o;
  logic [31:0] excp_addr_o;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;

  always #5 clk = ~clk;

  mem_lsu_stage #(
    .REG_ADDR_W (5),
    .ADDR_W     (32),
    .TIMEOUT    (TMO),
    .CNT_W      (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .flush_i     (flush_i),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .wdata_i     (wdata_i),
    .mem_op_i    (mem_op_i),
    .mem_addr_i  (mem_addr_i),
    .mem_sdata_i (mem_sdata_i),
    .dm_req_o    (dm_req_o),
    .dm_we_o     (dm_we_o),
    .dm_be_o     (dm_be_o),
    .dm_addr_o   (dm_addr_o),
    .dm_wdata_o  (dm_wdata_o),
    .dm_ack_i    (dm_ack_i),
    .dm_rdata_i  (dm_rdata_i),
    .wb_valid_o  (wb_valid_o),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .stall_req_o (stall_req_o),
    .excp_o      (excp_o),
    .excp_code_o (excp_code_o),
    .excp_addr_o (excp_addr_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (txn %0d): got=%h expected=%h", tag, txn_no, got, exp);
    end
  endtask

  // Access width in bytes from the op table; 0 means not a memory op.
  function automatic int size_of(input int op);
    if (op == 1 || op == 2 || op == 6) return 1;
    if (op == 3 || op == 4 || op == 7) return 2;
    if (op == 5 || op == 8) return 4;
    return 0;
  endfunction

  // One complete transaction: idle cycle, issue, then completion.
  // ack_after = number of WAIT cycles before ack; flush_at = WAIT cycle in
  // which flush_i is pulsed (0 = never).
  task automatic run_txn(input int op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] alu, input int ack_after, input int flush_at,
                         input logic flush_idle);
    int          size, idx, ack_k, end_k;
    bit          is_load, is_store, signed_ld, misal, flushed, timed_out;
    longint      mask, v;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_ld;

    txn_no++;
    size      = size_of(op);
    is_load   = (op >= 1 && op <= 5);
    is_store  = (op >= 6 && op <= 8);
    signed_ld = (op == 1 || op == 3);
    idx       = int'(addr % 4);
    misal     = (size != 0) && ((addr % size) != 0);
    exp_be    = 4'b0000;
    exp_wdata = 32'h0;
    exp_ld    = 32'h0;
    if (size != 0 && !misal) begin
      exp_be = 4'(((1 << size) - 1) << (4 - size - idx));
      if (size == 1) exp_wdata = (sdata & 32'hFF) * 32'h0101_0101;
      else if (size == 2) exp_wdata = (sdata & 32'hFFFF) * 32'h0001_0001;
      else exp_wdata = sdata;
      mask = (64'd1 << (8 * size)) - 1;
      v    = (longint'(rdata) >> (8 * (4 - size - idx))) & mask;
      if (signed_ld && v[8*size-1]) v = v | ~mask;
      exp_ld = v[31:0];
    end
    ack_k     = ack_after + 1;
    timed_out = (ack_k > TMO);
    end_k     = timed_out ? TMO : ack_k;
    flushed   = (flush_at >= 1) && (flush_at <= end_k);

    $display("txn %0d op=%0d addr=%h sdata=%h rdata=%h wd=%0d wreg=%0d ack_after=%0d flush_at=%0d flush_idle=%0d",
             txn_no, op, addr, sdata, rdata, wd, wreg, ack_after, flush_at, flush_idle);

    // idle cycle: nothing was accepted on the previous edge
    @(negedge clk);
    check("idle_wb_valid", 32'(wb_valid_o), 32'd0);
    check("idle_wreg", 32'(wreg_o), 32'd0);
    check("idle_excp", 32'(excp_o), 32'd0);
    check("idle_ready", 32'(ready_o), 32'd1);
    check("idle_req", 32'(dm_req_o), 32'd0);

    @(posedge clk); #1;
    valid_i = 1'b1; mem_op_i = 4'(op); mem_addr_i = addr; mem_sdata_i = sdata;
    wd_i = wd; wreg_i = wreg; wdata_i = alu; flush_i = flush_idle;
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0; mem_op_i = 4'($urandom_range(0, 15));

    if (flush_idle) begin
      @(negedge clk);
      check("flush_idle_wb_valid", 32'(wb_valid_o), 32'd0);
      check("flush_idle_req", 32'(dm_req_o), 32'd0);
      check("flush_idle_excp", 32'(excp_o), 32'd0);
    end else if (size == 0) begin
      @(negedge clk);
      check("alu_wb_valid", 32'(wb_valid_o), 32'd1);
      check("alu_wd", 32'(wd_o), 32'(wd));
      check("alu_wreg", 32'(wreg_o), 32'(wreg));
      check("alu_wdata", wdata_o, alu);
      check("alu_no_req", 32'(dm_req_o), 32'd0);
    end else if (misal) begin
      @(negedge clk);
      check("mis_excp", 32'(excp_o), 32'd1);
      check("mis_code", 32'(excp_code_o), is_load ? 32'd1 : 32'd2);
      check("mis_addr", excp_addr_o, addr);
      check("mis_wb_valid", 32'(wb_valid_o), 32'd1);
      check("mis_wreg", 32'(wreg_o), 32'd0);
      check("mis_no_req", 32'(dm_req_o), 32'd0);
      check("mis_ready", 32'(ready_o), 32'd1);
    end else begin
      for (int k = 1; k <= end_k; k++) begin
        dm_ack_i   = (k == ack_k);
        flush_i    = (k == flush_at);
        dm_rdata_i = (k == ack_k) ? rdata : $urandom;
        @(negedge clk);
        check("req_held", 32'(dm_req_o), 32'd1);
        check("stall", 32'(stall_req_o), (k == ack_k) ? 32'd0 : 32'd1);
        check("req_addr", dm_addr_o, addr & 32'hFFFF_FFFC);
        check("req_be", 32'(dm_be_o), 32'(exp_be));
        if (k == 1) begin
          check("wait_ready", 32'(ready_o), 32'd0);
          check("req_we", 32'(dm_we_o), 32'(is_store));
          if (is_store) check("req_wdata", dm_wdata_o, exp_wdata);
        end
        @(posedge clk); #1;
        dm_ack_i = 1'b0; flush_i = 1'b0;
      end
      @(negedge clk);
      check("done_req", 32'(dm_req_o), 32'd0);
      check("done_ready", 32'(ready_o), 32'd1);
      check("done_wreg", 32'(wreg_o), (is_load && wreg && !flushed && !timed_out) ? 32'd1 : 32'd0);
      if (timed_out) begin
        check("tmo_excp", 32'(excp_o), 32'd1);
        check("tmo_code", 32'(excp_code_o), 32'd3);
        check("tmo_addr", excp_addr_o, addr);
      end else begin
        check("done_excp", 32'(excp_o), 32'd0);
        check("done_wb_valid", 32'(wb_valid_o), 32'd1);
        check("done_wd", 32'(wd_o), 32'(wd));
        if (is_load) check("load_data", wdata_o, exp_ld);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int op, sz, ack_after, flush_at;
    logic [31:0] addr;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(dm_req_o), 32'd0);
    check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    check("rst_excp", 32'(excp_o), 32'd0);
    check("rst_stall", 32'(stall_req_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // directed cases
    run_txn(0, 32'h0, 32'h0, 32'h0, 5'd3, 1'b1, 32'h1234, 0, 0, 1'b0);
    run_txn(1, 32'h1001, 32'h0, 32'h11F2_3344, 5'd7, 1'b1, 32'h0, 3, 0, 1'b0);
    run_txn(2, 32'h1001, 32'h0, 32'h11F2_3344, 5'd7, 1'b1, 32'h0, 3, 0, 1'b0);
    run_txn(7, 32'h2002, 32'hABCD, 32'h0, 5'd2, 1'b1, 32'h0, 1, 0, 1'b0);
    run_txn(5, 32'h3001, 32'h0, 32'h0, 5'd4, 1'b1, 32'h0, 0, 0, 1'b0);
    run_txn(5, 32'h4000, 32'h0, 32'h0, 5'd5, 1'b1, 32'h0, 20, 0, 1'b0);
    run_txn(3, 32'h5002, 32'h0, 32'h1234_8765, 5'd6, 1'b1, 32'h0, 2, 1, 1'b0);
    run_txn(5, 32'h6000, 32'h0, 32'hCAFE_F00D, 5'd8, 1'b1, 32'h0, TMO - 1, 0, 1'b0);
    run_txn(0, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1, 32'h55, 0, 0, 1'b1);

    // reset asserted mid-WAIT
    txn_no++;
    $display("txn %0d reset during WAIT", txn_no);
    valid_i = 1'b1; mem_op_i = 4'd5; mem_addr_i = 32'h7000; wd_i = 5'd1; wreg_i = 1'b1; flush_i = 1'b0;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    check("pre_rst_req", 32'(dm_req_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_req", 32'(dm_req_o), 32'd0);
    check("async_rst_stall", 32'(stall_req_o), 32'd0);
    check("async_rst_ready", 32'(ready_o), 32'd0);
    check("async_rst_be", 32'(dm_be_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_txn(0, 32'h0, 32'h0, 32'h0, 5'd11, 1'b1, 32'hBEEF, 0, 0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      op   = $urandom_range(0, 11);
      sz   = size_of(op);
      addr = $urandom;
      if (sz > 1 && $urandom_range(0, 2) != 0) addr = addr & ~(32'(sz) - 1);
      ack_after = $urandom_range(0, TMO + 1);
      flush_at  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TMO) : 0;
      run_txn(op, addr, $urandom, $urandom, 5'($urandom), 1'($urandom),
              $urandom, ack_after, flush_at, ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_lsu_stage.md
Name: mem_lsu_stage

Overview:
Pipelined successor of the combinational MEM pass-through stage. It registers EX results into a MEM/WB output and performs load/store accesses to data memory over a req/ack handshake. Byte-lane steering, load sign/zero extension, misalignment detection and a bus-timeout counter are included. It sits between the EX/MEM latch and the WB/regfile write port, and raises a stall request to the pipeline controller.

Parameters:
REG_ADDR_W, 5, register-file address width
ADDR_W, 32, data-memory byte-address width
TIMEOUT, 255, max cycles waiting for dm_ack_i before bus error (1..2^CNT_W-1)
CNT_W, 8, timeout counter width

Ports:
clk  in  1  stage clock
rst  in  1  asynchronous active-low reset; 0 = reset
valid_i  in  1  EX/MEM slot holds an instruction
ready_o  out  1  stage can accept this cycle
flush_i  in  1  discard in-flight/incoming instruction
wd_i  in  REG_ADDR_W  destination register
wreg_i  in  1  write-enable from EX
wdata_i  in  32  ALU result
mem_op_i  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; others = NONE
mem_addr_i  in  ADDR_W  effective address
mem_sdata_i  in  32  store data (low bits significant)
dm_req_o  out  1  memory request, held until ack
dm_we_o  out  1  1 = store
dm_be_o  out  4  byte enables, big-endian (bit3 = addr 00)
dm_addr_o  out  ADDR_W  word-aligned address (low 2 bits 0)
dm_wdata_o  out  32  lane-replicated store data
dm_ack_i  in  1  one-cycle completion strobe
dm_rdata_i  in  32  read word, valid with ack
wb_valid_o  out  1  WB slot valid
wd_o  out  REG_ADDR_W  WB destination
wreg_o  out  1  WB write enable
wdata_o  out  32  WB data
stall_req_o  out  1  hold upstream stages
excp_o  out  1  one-cycle exception pulse
excp_code_o  out  2  0 none, 1 load misaligned, 2 store misaligned, 3 bus timeout
excp_addr_o  out  ADDR_W  faulting address

Behaviour:
- Reset (rst=0, async): all outputs and state 0; state IDLE; counter 0. Release is synchronous to clk.
- FSM states: IDLE, WAIT. ready_o = (state==IDLE). stall_req_o = (state==WAIT) && !dm_ack_i.
- IDLE, accept = valid_i && !flush_i:
  - NONE: next edge WB regs <= {1, wd_i, wreg_i, wdata_i}. Latency 1.
  - Aligned mem op: next edge dm_req_o=1 and address/be/wdata/op/wd are latched; go to WAIT.
  - Alignment rules: H needs addr[0]=0; W needs addr[1:0]=0.
  - Misaligned: no request; WB regs <= {1, wd_i, 0, 0}; excp_o=1 with code 1 (load) or 2 (store) and addr; stay IDLE.
- No accept: wb_valid_o=0 and wreg_o=0 next cycle. excp_o is always a single-cycle pulse.
- Lanes (big-endian):
  - B: be = 1000 >> addr[1:0]; wdata = {4{sdata[7:0]}}.
  - H: be = 1100 at addr 00, 0011 at addr 10; wdata = {2{sdata[15:0]}}.
  - W: be = 1111.
  - Loads assert the same be with we=0.
- WAIT:
  - Counter increments each cycle.
  - On dm_ack_i: dm_req_o drops the next edge.
    - Load: WB <= {1, wd, wreg_lat, extend(selected lane)}. LB/LH sign-extend; LBU/LHU zero-extend.
    - Store: WB <= {1, wd, 0, 0}.
    - Return to IDLE; counter cleared.
  - Counter reaches TIMEOUT without ack: drop req; excp code 3; WB wreg_o=0; IDLE.
- Flush in WAIT: the request is not aborted and completes normally, but the result is written with wreg_o=0. Flush in IDLE suppresses accept.
- Ack and timeout on the same cycle: ack wins.
- Ack outside WAIT: ignored.
- Request outputs are stable while in WAIT.

Decomposition:
- Shared package: mem_op encodings, excp codes, FSM state encoding, NOPRegAddr/ZeroWord constants.
- Sub-module lsu_lane_align (combinational): store lane steering/be generation plus load lane select/extend. Used once here; reusable by a future cache.

Test Plan:
- Reset mid-WAIT: rst=0 while dm_req_o=1 -> all outputs 0 immediately; after release, the first accepted NONE op appears on WB one cycle later.
- ALU passthrough: valid_i=1, NONE, wd=3, wreg=1, wdata=0x1234 -> next cycle wb_valid_o=1, wd_o=3, wdata_o=0x1234; no dm_req_o.
- LB addr 0x1001, dm_rdata 0x11F2_3344, ack after 3 cycles:
  - dm_be_o=0100, dm_addr_o=0x1000, stall_req_o high for 3 cycles.
  - wdata_o=0xFFFF_FFF2. The same access with LBU gives 0x0000_00F2.
- SH addr 0x2002, sdata 0xABCD -> dm_we_o=1, be=0011, wdata=0xABCD_ABCD; after ack, wreg_o=0.
- LW addr 0x3001 -> no req; excp_o=1, code 1, excp_addr_o=0x3001; wreg_o=0.
- TIMEOUT=4, no ack -> req held exactly 4 cycles then dropped; excp code 3; ready_o=1 the next cycle.
- Flush in WAIT, then ack -> wb_valid_o=1 with wreg_o=0.
